// File: rtl/rule_packer.sv
// rule_packer
//
// Packs the rule IDs of each packet arriving from the root of the rule
// reduction tree into wide words of NUM_SLOTS slots. Each packet ends with one
// entry whose last bit is set. The final word of a packet carries eop, the
// number of rules reported (capped at MAX_RULES) and an overflow flag that
// says whether any rules were dropped by the cap.
//
// Ports:
//   clk        single clock
//   rst_n      asynchronous active-low reset
//   in_data    rule_s_t entry, packed as {last, rule_id}
//   in_valid   in_data valid
//   in_ready   entry accepted when in_valid & in_ready
//   out_rules  slot k at bits [k*RULE_W +: RULE_W], slot 0 holds the first rule
//   out_mask   bit k set when slot k is valid (contiguous low-order run)
//   out_eop    last word of the packet
//   out_cnt    rules reported for the packet on eop words, 0 otherwise
//   out_ovf    on eop words, at least one rule was dropped by the cap
//   out_valid  output word valid
//   out_ready  downstream accept
module rule_packer #(
    parameter int NUM_SLOTS = 4,
    parameter int RULE_W    = 16,
    parameter int MAX_RULES = 32,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [RULE_W:0]             in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [NUM_SLOTS*RULE_W-1:0] out_rules,
    output logic [NUM_SLOTS-1:0]        out_mask,
    output logic                        out_eop,
    output logic [CNT_W-1:0]            out_cnt,
    output logic                        out_ovf,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int IDX_W = $clog2(NUM_SLOTS + 1);
    localparam int CW    = $clog2(MAX_RULES + 1);

    typedef struct packed {
        logic              last;
        logic [RULE_W-1:0] rule_id;
    } rule_s_t;

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    rule_s_t                 entry;
    state_t                  state, state_nx;
    logic [NUM_SLOTS*RULE_W-1:0] acc_rules, acc_rules_nx;
    logic [NUM_SLOTS-1:0]    acc_mask, acc_mask_nx;
    logic [IDX_W-1:0]        slot_idx, slot_idx_nx;
    logic [CW-1:0]           rule_cnt, rule_cnt_nx;
    logic                    ovf_flag, ovf_flag_nx;
    logic                    out_free;
    logic                    at_cap;
    logic                    accept;
    logic                    emit;
    logic                    emit_eop;

    assign entry    = rule_s_t'(in_data);
    assign out_free = !out_valid || out_ready;
    assign at_cap   = (rule_cnt == CW'(MAX_RULES));

    // Accumulator and packet bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            acc_rules <= '0;
            acc_mask  <= '0;
            slot_idx  <= '0;
            rule_cnt  <= '0;
            ovf_flag  <= 1'b0;
        end else begin
            state     <= state_nx;
            acc_rules <= acc_rules_nx;
            acc_mask  <= acc_mask_nx;
            slot_idx  <= slot_idx_nx;
            rule_cnt  <= rule_cnt_nx;
            ovf_flag  <= ovf_flag_nx;
        end
    end

    // Next-state logic. A full accumulator is parked in HOLD rather than
    // emitted at once, so that a last arriving next can still tag it with eop
    // instead of producing an extra empty eop word. Only entries that would
    // load the output register wait for out_free; dropped entries and plain
    // slot writes in FILL are always accepted.
    always_comb begin
        state_nx     = state;
        acc_rules_nx = acc_rules;
        acc_mask_nx  = acc_mask;
        slot_idx_nx  = slot_idx;
        rule_cnt_nx  = rule_cnt;
        ovf_flag_nx  = ovf_flag;
        emit         = 1'b0;
        emit_eop     = 1'b0;
        in_ready     = 1'b1;

        case (state)
            FILL:    if (entry.last) in_ready = out_free;
            HOLD:    if (entry.last || !at_cap) in_ready = out_free;
            default: in_ready = 1'b1;
        endcase

        accept = in_valid && in_ready;

        if (accept) begin
            if (entry.last) begin
                emit         = 1'b1;
                emit_eop     = 1'b1;
                acc_rules_nx = '0;
                acc_mask_nx  = '0;
                slot_idx_nx  = '0;
                rule_cnt_nx  = '0;
                ovf_flag_nx  = 1'b0;
                state_nx     = FILL;
            end else if (at_cap) begin
                ovf_flag_nx = 1'b1;
            end else if (state == HOLD) begin
                // Flush the full word and start the next one with this rule.
                emit                       = 1'b1;
                acc_rules_nx               = '0;
                acc_rules_nx[RULE_W-1:0]   = entry.rule_id;
                acc_mask_nx                = '0;
                acc_mask_nx[0]             = 1'b1;
                slot_idx_nx                = IDX_W'(1);
                rule_cnt_nx                = rule_cnt + CW'(1);
                state_nx                   = FILL;
            end else begin
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    if (slot_idx == IDX_W'(k)) begin
                        acc_rules_nx[k*RULE_W +: RULE_W] = entry.rule_id;
                        acc_mask_nx[k]                   = 1'b1;
                    end
                end
                slot_idx_nx = slot_idx + IDX_W'(1);
                rule_cnt_nx = rule_cnt + CW'(1);
                if (slot_idx_nx == IDX_W'(NUM_SLOTS)) begin
                    state_nx = HOLD;
                end
            end
        end
    end

    // Output word register. emit is only raised for accepted entries whose
    // acceptance required out_free, so a held word is never overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_rules <= '0;
            out_mask  <= '0;
            out_eop   <= 1'b0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_rules <= acc_rules;
            out_mask  <= acc_mask;
            out_eop   <= emit_eop;
            out_cnt   <= emit_eop ? CNT_W'(rule_cnt) : '0;
            out_ovf   <= emit_eop && ovf_flag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rule_packer.sv
// tb_rule_packer
//
// Self-checking bench for rule_packer. Expected words come from a packet-level
// model: keep the first MAX_RULES ids, chop them into NUM_SLOTS-wide words
// (one empty word for an empty packet) and tag the final word with eop, the
// kept count and whether anything was dropped.
module tb_rule_packer;

    localparam int NS    = 4;
    localparam int RW    = 16;
    localparam int MAXR  = 32;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [NS*RW-1:0] rules;
        logic [NS-1:0]    mask;
        logic             eop;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } word_t;

    logic              clk;
    logic              rst_n;
    logic [RW:0]       in_data;
    logic              in_valid;
    logic              in_ready;
    logic [NS*RW-1:0]  out_rules;
    logic [NS-1:0]     out_mask;
    logic              out_eop;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_ovf;
    logic              out_valid;
    logic              out_ready;

    word_t exp_q[$];
    word_t obs_q[$];
    int    checks;
    int    fails;
    int    valid_cycles;
    int    stab_err;
    int    rdy_err;
    bit    rand_ready;
    bit    hold_ready;

    rule_packer #(
        .NUM_SLOTS(NS),
        .RULE_W(RW),
        .MAX_RULES(MAXR),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_rules(out_rules),
        .out_mask(out_mask),
        .out_eop(out_eop),
        .out_cnt(out_cnt),
        .out_ovf(out_ovf),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream ready: forced low, random, or always high.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold_ready ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: records handshaken words (unused slots zeroed), counts valid
    // cycles, and flags unstable held words or in_ready drops while out_free.
    initial begin
        word_t cur, prev;
        bit    prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cur = '{out_rules, out_mask, out_eop, out_cnt, out_ovf};
                if (out_valid) valid_cycles++;
                if (prev_stall && (!out_valid || cur !== prev)) stab_err++;
                if (in_valid && !in_ready && (!out_valid || out_ready)) rdy_err++;
                if (out_valid && out_ready) begin
                    word_t w;
                    w = cur;
                    for (int s = 0; s < NS; s++)
                        if (!out_mask[s]) w.rules[s*RW +: RW] = '0;
                    obs_q.push_back(w);
                end
                prev_stall = out_valid && !out_ready;
                prev = cur;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    function automatic void model_packet(input int ids[$]);
        int kept, nwords;
        kept   = (ids.size() > MAXR) ? MAXR : ids.size();
        nwords = (kept == 0) ? 1 : (kept + NS - 1) / NS;
        for (int w = 0; w < nwords; w++) begin
            word_t x;
            x = '0;
            for (int s = 0; s < NS; s++) begin
                if (w * NS + s < kept) begin
                    x.rules[s*RW +: RW] = RW'(ids[w * NS + s]);
                    x.mask[s] = 1'b1;
                end
            end
            if (w == nwords - 1) begin
                x.eop = 1'b1;
                x.cnt = CNT_W'(kept);
                x.ovf = (ids.size() > MAXR);
            end
            exp_q.push_back(x);
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 after the entry is accepted.
    task automatic drive_entry(input int id, input bit last);
        int cyc;
        in_valid = 1'b1;
        in_data  = {last, RW'(id)};
        cyc = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            cyc++;
            if (cyc > 1000) begin
                checks++;
                fails++;
                $display("[TB] FAIL accept_timeout: entry id=%0d last=%0b not accepted within 1000 cycles", id, last);
                @(posedge clk);
                #1;
                break;
            end
        end
    endtask

    task automatic send_packet(input int ids[$]);
        foreach (ids[i]) drive_entry(ids[i], 1'b0);
        drive_entry(int'($urandom_range(0, 65535)), 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int n);
        int cyc;
        cyc = 0;
        while (obs_q.size() < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (obs_q.size() < n) begin
            checks++;
            fails++;
            $display("[TB] FAIL drain_timeout: got %0d words, required %0d", obs_q.size(), n);
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic start_test();
        exp_q.delete();
        obs_q.delete();
        valid_cycles = 0;
        stab_err = 0;
        rdy_err = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({out_valid, out_rules, out_mask, out_eop, out_cnt, out_ovf} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got valid=%b rules=%h mask=%b eop=%b cnt=%0d ovf=%b, required all 0",
                     out_valid, out_rules, out_mask, out_eop, out_cnt, out_ovf);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int ids[$];
        start_test();
        ids = '{10, 11, 12};
        model_packet(ids);
        send_packet(ids);
        wait_drain(exp_q.size());
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++;
            $display("[TB] FAIL basic_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL basic_word %0d: got rules=%h mask=%b eop=%b cnt=%0d ovf=%b, required rules=%h mask=%b eop=%b cnt=%0d ovf=%b",
                         i, obs_q[i].rules, obs_q[i].mask, obs_q[i].eop, obs_q[i].cnt, obs_q[i].ovf,
                         exp_q[i].rules, exp_q[i].mask, exp_q[i].eop, exp_q[i].cnt, exp_q[i].ovf);
            end
        end
        checks++;
        if (valid_cycles != 1) begin
            fails++;
            $display("[TB] FAIL basic_valid_cycles: got %0d, required 1", valid_cycles);
        end
    endtask

    task automatic test_word_fill();
        int a[$];
        int b[$];
        start_test();
        a = '{1, 2, 3, 4};
        b = '{1, 2, 3, 4, 5};
        model_packet(a);
        model_packet(b);
        send_packet(a);
        send_packet(b);
        wait_drain(exp_q.size());
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++;
            $display("[TB] FAIL fill_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL fill_word %0d: got rules=%h mask=%b eop=%b cnt=%0d ovf=%b, required rules=%h mask=%b eop=%b cnt=%0d ovf=%b",
                         i, obs_q[i].rules, obs_q[i].mask, obs_q[i].eop, obs_q[i].cnt, obs_q[i].ovf,
                         exp_q[i].rules, exp_q[i].mask, exp_q[i].eop, exp_q[i].cnt, exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_back_to_back_empty();
        int e[$];
        int c[$];
        start_test();
        c = '{21, 22};
        model_packet(c);
        model_packet(e);
        model_packet(e);
        model_packet(c);
        send_packet(c);
        send_packet(e);
        send_packet(e);
        send_packet(c);
        wait_drain(exp_q.size());
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++;
            $display("[TB] FAIL empty_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL empty_word %0d: got rules=%h mask=%b eop=%b cnt=%0d ovf=%b, required rules=%h mask=%b eop=%b cnt=%0d ovf=%b",
                         i, obs_q[i].rules, obs_q[i].mask, obs_q[i].eop, obs_q[i].cnt, obs_q[i].ovf,
                         exp_q[i].rules, exp_q[i].mask, exp_q[i].eop, exp_q[i].cnt, exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_overflow();
        int big[$];
        int nxt[$];
        start_test();
        for (int i = 0; i < 40; i++) big.push_back(i);
        nxt = '{5, 6};
        model_packet(big);
        model_packet(nxt);
        send_packet(big);
        send_packet(nxt);
        wait_drain(exp_q.size());
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++;
            $display("[TB] FAIL ovf_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL ovf_word %0d: got rules=%h mask=%b eop=%b cnt=%0d ovf=%b, required rules=%h mask=%b eop=%b cnt=%0d ovf=%b",
                         i, obs_q[i].rules, obs_q[i].mask, obs_q[i].eop, obs_q[i].cnt, obs_q[i].ovf,
                         exp_q[i].rules, exp_q[i].mask, exp_q[i].eop, exp_q[i].cnt, exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_backpressure();
        int ids[$];
        start_test();
        rand_ready = 1'b1;
        for (int p = 0; p < 5; p++) begin
            int len;
            ids.delete();
            len = (p == 0) ? 9 : int'($urandom_range(0, 40));
            for (int i = 0; i < len; i++) ids.push_back(int'($urandom_range(0, 65535)));
            model_packet(ids);
            send_packet(ids);
        end
        wait_drain(exp_q.size());
        rand_ready = 1'b0;
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++;
            $display("[TB] FAIL bp_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL bp_word %0d: got rules=%h mask=%b eop=%b cnt=%0d ovf=%b, required rules=%h mask=%b eop=%b cnt=%0d ovf=%b",
                         i, obs_q[i].rules, obs_q[i].mask, obs_q[i].eop, obs_q[i].cnt, obs_q[i].ovf,
                         exp_q[i].rules, exp_q[i].mask, exp_q[i].eop, exp_q[i].cnt, exp_q[i].ovf);
            end
        end
        checks++;
        if (stab_err != 0) begin
            fails++;
            $display("[TB] FAIL bp_stability: got %0d unstable held words, required 0", stab_err);
        end
        checks++;
        if (rdy_err != 0) begin
            fails++;
            $display("[TB] FAIL bp_in_ready: got %0d in_ready drops with output free, required 0", rdy_err);
        end
    endtask

    task automatic test_mid_reset();
        int pend[$];
        int ids[$];
        start_test();
        hold_ready = 1'b1;
        @(posedge clk);
        #1;
        pend = '{3};
        send_packet(pend);
        drive_entry(40, 1'b0);
        drive_entry(41, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_rules, out_mask, out_eop, out_cnt, out_ovf} !== '0) begin
            fails++;
            $display("[TB] FAIL midreset_outputs: got valid=%b mask=%b eop=%b cnt=%0d ovf=%b, required all 0",
                     out_valid, out_mask, out_eop, out_cnt, out_ovf);
        end
        hold_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ids = '{7};
        model_packet(ids);
        send_packet(ids);
        wait_drain(exp_q.size());
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++;
            $display("[TB] FAIL midreset_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL midreset_word %0d: got rules=%h mask=%b eop=%b cnt=%0d ovf=%b, required rules=%h mask=%b eop=%b cnt=%0d ovf=%b",
                         i, obs_q[i].rules, obs_q[i].mask, obs_q[i].eop, obs_q[i].cnt, obs_q[i].ovf,
                         exp_q[i].rules, exp_q[i].mask, exp_q[i].eop, exp_q[i].cnt, exp_q[i].ovf);
            end
        end
    endtask

    initial begin
        checks       = 0;
        fails        = 0;
        valid_cycles = 0;
        stab_err     = 0;
        rdy_err      = 0;
        rand_ready   = 1'b0;
        hold_ready   = 1'b0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_word_fill();
        test_back_to_back_empty();
        test_overflow();
        test_backpressure();
        test_mid_reset();
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
